ex_mem_stage: RTL and testbench

Pipeline stage directly downstream of the 64-bit ALU. It captures each ALU result together with its store data, destination register and control bits, and presents them to the data-memory stage. It resolves CBZ and B branches from the ALU zero flag and reports the redirect to fetch. It contains a 2-entry buffer with valid/ready handshakes so that a memory stall never drops an ALU result.

---
 rtl/ex_mem_pkg.sv | 32 +++
 rtl/ex_mem_skid_buf.sv | 84 ++++++++
 rtl/ex_mem_stage.sv | 78 +++++++
 tb/tb_ex_mem_stage.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX/MEM pipeline stage: control-bit positions,
// default widths and the layout of a buffered entry.
package ex_mem_pkg;

   localparam int DEF_DATA_W = 64;
   localparam int DEF_REG_W  = 5;

   // Bit positions inside the 6-bit ctl bundle from decode
   localparam int CTL_MEM_READ   = 0;
   localparam int CTL_MEM_WRITE  = 1;
   localparam int CTL_REG_WRITE  = 2;
   localparam int CTL_MEM_TO_REG = 3;
   localparam int CTL_BR_CBZ     = 4;
   localparam int CTL_BR_UNCOND  = 5;

   // Only the low four ctl bits travel on to the memory stage
   localparam int MEM_CTL_W = 4;

   typedef struct packed {
      logic [DEF_DATA_W-1:0] addr;
      logic [DEF_DATA_W-1:0] wdata;
      logic [DEF_REG_W-1:0]  rd;
      logic [MEM_CTL_W-1:0]  mem_ctl;
   } entry_t;

   // An entry with no memory access and no writeback has nothing for the
   // memory stage to do; it only matters for its branch outcome.
   function automatic logic is_pure_branch(input logic [5:0] ctl);
      return ~(ctl[CTL_MEM_READ] | ctl[CTL_MEM_WRITE] | ctl[CTL_REG_WRITE]);
   endfunction

endpackage

// File: rtl/ex_mem_skid_buf.sv
// Generic in-order 2-entry valid/ready buffer (head + skid). in_ready is
// derived from registered state only, so there is no combinational path
// from out_ready back to in_ready.
module ex_mem_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic [1:0]   count_reg, count_next;
   logic [W-1:0] head_reg, head_next;
   logic [W-1:0] skid_reg, skid_next;
   logic         live_reg;
   logic         push, pop;

   // live_reg holds in_ready low during reset and releases it on the first edge after
   assign in_ready  = live_reg & (count_reg != 2'd2);
   assign out_valid = (count_reg != 2'd0);
   assign out_data  = head_reg;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Next-state for occupancy and the two data registers; clr wins over everything
   always_comb begin
      count_next = count_reg;
      head_next  = head_reg;
      skid_next  = skid_reg;
      if (clr) begin
         count_next = 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count_reg == 2'd0) begin
                  head_next  = in_data;
                  count_next = 2'd1;
               end else begin
                  skid_next  = in_data;
                  count_next = 2'd2;
               end
            end
            2'b01: begin
               if (count_reg == 2'd2) begin
                  head_next  = skid_reg;
                  count_next = 2'd1;
               end else begin
                  count_next = 2'd0;
               end
            end
            2'b11: begin
               // push implies count < 2 and pop implies count > 0, so count == 1
               head_next  = in_data;
               count_next = 2'd1;
            end
            default: begin
               count_next = count_reg;
            end
         endcase
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= 2'd0;
         head_reg  <= '0;
         skid_reg  <= '0;
         live_reg  <= 1'b0;
      end else begin
         count_reg <= count_next;
         head_reg  <= head_next;
         skid_reg  <= skid_next;
         live_reg  <= 1'b1;
      end
   end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM stage: buffers ALU results for the memory stage, resolves CBZ/B
// branches on accept and drops pure-branch entries instead of queueing them.
module ex_mem_stage
   import ex_mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_W  = DEF_REG_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_zero,
   input  logic [DATA_W-1:0] store_data,
   input  logic [DATA_W-1:0] br_target,
   input  logic [REG_W-1:0]  rd,
   input  logic [5:0]        ctl,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [REG_W-1:0]  mem_rd,
   output logic [3:0]        mem_ctl,
   output logic              br_taken,
   output logic [DATA_W-1:0] br_pc
);

   localparam int ENTRY_W = 2 * DATA_W + REG_W + MEM_CTL_W;

   logic               accept;
   logic               taken;
   logic               pure_branch;
   logic               buf_in_valid;
   logic [ENTRY_W-1:0] in_entry;
   logic [ENTRY_W-1:0] head_entry;
   logic               br_taken_reg;
   logic [DATA_W-1:0]  br_pc_reg;

   assign accept      = ex_valid & ex_ready;
   assign taken       = ctl[CTL_BR_UNCOND] | (ctl[CTL_BR_CBZ] & alu_zero);
   assign pure_branch = is_pure_branch(ctl);
   // A flushed accept must not reach the buffer; clr also empties it
   assign buf_in_valid = ex_valid & ~pure_branch & ~flush;
   assign in_entry     = {alu_out, store_data, rd, ctl[MEM_CTL_W-1:0]};

   ex_mem_skid_buf #(
      .W (ENTRY_W)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (flush),
      .in_valid  (buf_in_valid),
      .in_ready  (ex_ready),
      .in_data   (in_entry),
      .out_valid (mem_valid),
      .out_ready (mem_ready),
      .out_data  (head_entry)
   );

   assign {mem_addr, mem_wdata, mem_rd, mem_ctl} = head_entry;

   // One-cycle redirect pulse for a taken branch accepted without a flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_taken_reg <= 1'b0;
         br_pc_reg    <= '0;
      end else begin
         br_taken_reg <= accept & taken & ~flush;
         br_pc_reg    <= (accept & taken & ~flush) ? br_target : '0;
      end
   end

   assign br_taken = br_taken_reg;
   assign br_pc    = br_pc_reg;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: a queue-based reference model predicts
// buffer contents, readiness and branch pulses; a negedge monitor compares.
module tb_ex_mem_stage;

   typedef struct packed {
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [4:0]  rd;
      logic [3:0]  ctl;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        ex_valid;
   logic        ex_ready;
   logic [63:0] alu_out;
   logic        alu_zero;
   logic [63:0] store_data;
   logic [63:0] br_target;
   logic [4:0]  rd;
   logic [5:0]  ctl;
   logic        mem_valid;
   logic        mem_ready;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [4:0]  mem_rd;
   logic [3:0]  mem_ctl;
   logic        br_taken;
   logic [63:0] br_pc;

   int total = 0;
   int bad   = 0;
   int illegal_seen = 0;
   int pushes = 0;
   int pops   = 0;

   // reference model state
   exp_t        q[$];
   bit          live = 0;
   bit          exp_br = 0;
   logic [63:0] exp_br_pc = '0;

   ex_mem_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .ex_valid   (ex_valid),
      .ex_ready   (ex_ready),
      .alu_out    (alu_out),
      .alu_zero   (alu_zero),
      .store_data (store_data),
      .br_target  (br_target),
      .rd         (rd),
      .ctl        (ctl),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rd     (mem_rd),
      .mem_ctl    (mem_ctl),
      .br_taken   (br_taken),
      .br_pc      (br_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: a bounded FIFO of depth 2 plus a branch-pulse latch
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            q.delete();
            live      = 0;
            exp_br    = 0;
            exp_br_pc = '0;
         end else if (!live) begin
            live      = 1;
            exp_br    = 0;
            exp_br_pc = '0;
         end else begin
            bit acc, drn;
            acc = ex_valid && (q.size() < 2);
            drn = (q.size() > 0) && mem_ready;
            if (flush) begin
               q.delete();
               exp_br    = 0;
               exp_br_pc = '0;
            end else begin
               if (drn) begin
                  void'(q.pop_front());
                  pops++;
               end
               if (acc && (ctl[0] || ctl[1] || ctl[2])) begin
                  exp_t e;
                  e.addr  = alu_out;
                  e.wdata = store_data;
                  e.rd    = rd;
                  e.ctl   = ctl[3:0];
                  q.push_back(e);
                  pushes++;
                  if (ctl[0] && ctl[1]) illegal_seen++;
               end
               exp_br    = acc && (ctl[5] || (ctl[4] && alu_zero));
               exp_br_pc = exp_br ? br_target : '0;
            end
         end
      end
   end

   // Monitor: compare DUT outputs against the model away from the clock edge
   initial begin
      forever begin
         @(negedge clk);
         chk("ex_ready", {63'd0, ex_ready}, {63'd0, (live && q.size() < 2)});
         chk("mem_valid", {63'd0, mem_valid}, {63'd0, (q.size() != 0)});
         chk("br_taken", {63'd0, br_taken}, {63'd0, exp_br});
         if (exp_br) chk("br_pc", br_pc, exp_br_pc);
         if (q.size() != 0) begin
            chk("mem_addr", mem_addr, q[0].addr);
            chk("mem_wdata", mem_wdata, q[0].wdata);
            chk("mem_rd", {59'd0, mem_rd}, {59'd0, q[0].rd});
            chk("mem_ctl", {60'd0, mem_ctl}, {60'd0, q[0].ctl});
         end
      end
   end

   // Time limit so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] w,
                        input logic [4:0] r, input logic [5:0] c, input logic z,
                        input logic [63:0] t);
      ex_valid   = v;
      alu_out    = a;
      store_data = w;
      rd         = r;
      ctl        = c;
      alu_zero   = z;
      br_target  = t;
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      mem_ready = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);

      // reset state
      tick(); tick(); tick();
      chk("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
      chk("rst_ex_ready", {63'd0, ex_ready}, 64'd0);
      chk("rst_mem_addr", mem_addr, 64'd0);
      chk("rst_mem_ctl", {60'd0, mem_ctl}, 64'd0);
      chk("rst_br_taken", {63'd0, br_taken}, 64'd0);
      chk("rst_br_pc", br_pc, 64'd0);
      rst_n = 1'b1;
      tick();
      chk("ready_after_release", {63'd0, ex_ready}, 64'd1);

      // ADD -> one-cycle latency
      mem_ready = 1'b1;
      drive(1, 64'h10, 64'h0, 5'd3, 6'b000100, 0, 64'h0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      $display("tx add addr=0x10 rd=3");
      chk("add_valid", {63'd0, mem_valid}, 64'd1);
      chk("add_addr", mem_addr, 64'h10);
      chk("add_rd", {59'd0, mem_rd}, 64'd3);
      chk("add_ctl", {60'd0, mem_ctl}, 64'b0100);
      chk("add_br", {63'd0, br_taken}, 64'd0);
      tick();

      // three STURs under stall
      mem_ready = 1'b0;
      drive(1, 64'h8, 64'hA8, 5'd0, 6'b000010, 0, 0);
      tick();
      drive(1, 64'h10, 64'hB0, 5'd0, 6'b000010, 0, 0);
      tick();
      drive(1, 64'h18, 64'hB8, 5'd0, 6'b000010, 0, 0);
      chk("stur_full_ready", {63'd0, ex_ready}, 64'd0);
      tick();
      chk("stur_full_ready2", {63'd0, ex_ready}, 64'd0);
      chk("stur_hold_addr", mem_addr, 64'h8);
      mem_ready = 1'b1;
      tick();
      $display("tx stur drained addr=0x8");
      chk("stur_second", mem_addr, 64'h10);
      chk("stur_ready_back", {63'd0, ex_ready}, 64'd1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      $display("tx stur drained addr=0x10");
      chk("stur_third", mem_addr, 64'h18);
      chk("stur_third_valid", {63'd0, mem_valid}, 64'd1);
      tick();
      $display("tx stur drained addr=0x18");
      chk("stur_empty", {63'd0, mem_valid}, 64'd0);

      // CBZ taken and not taken
      drive(1, 64'h0, 64'h0, 5'd0, 6'b010000, 1, 64'h40);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      $display("tx cbz zero=1 target=0x40");
      chk("cbz_taken", {63'd0, br_taken}, 64'd1);
      chk("cbz_pc", br_pc, 64'h40);
      chk("cbz_not_enq", {63'd0, mem_valid}, 64'd0);
      tick();
      chk("cbz_pulse_end", {63'd0, br_taken}, 64'd0);
      drive(1, 64'h5, 64'h0, 5'd0, 6'b010000, 0, 64'h40);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      $display("tx cbz zero=0 target=0x40");
      chk("cbz_nt", {63'd0, br_taken}, 64'd0);
      chk("cbz_nt_not_enq", {63'd0, mem_valid}, 64'd0);

      // flush with full buffer and a coincident B
      mem_ready = 1'b0;
      drive(1, 64'h100, 64'h0, 5'd1, 6'b000100, 0, 0);
      tick();
      drive(1, 64'h108, 64'h0, 5'd2, 6'b000100, 0, 0);
      tick();
      drive(1, 64'h0, 64'h0, 5'd0, 6'b100000, 0, 64'h80);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      $display("tx flush count=2 with B 0x80");
      chk("flush_valid", {63'd0, mem_valid}, 64'd0);
      chk("flush_br", {63'd0, br_taken}, 64'd0);
      chk("flush_ready", {63'd0, ex_ready}, 64'd1);

      // flush with count=1 discards an accepted B
      drive(1, 64'h110, 64'h0, 5'd4, 6'b000100, 0, 0);
      tick();
      drive(1, 64'h0, 64'h0, 5'd0, 6'b100000, 0, 64'h88);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      $display("tx flush count=1 with accepted B 0x88");
      chk("flush1_br", {63'd0, br_taken}, 64'd0);
      chk("flush1_valid", {63'd0, mem_valid}, 64'd0);

      // a pulse registered before a flush still appears
      drive(1, 64'h0, 64'h0, 5'd0, 6'b100000, 0, 64'h90);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      flush = 1'b1;
      $display("tx B 0x90 then flush");
      chk("preflush_br", {63'd0, br_taken}, 64'd1);
      chk("preflush_pc", br_pc, 64'h90);
      tick();
      flush = 1'b0;
      chk("preflush_end", {63'd0, br_taken}, 64'd0);

      // asynchronous reset mid-stall
      drive(1, 64'h200, 64'h0, 5'd5, 6'b000100, 0, 0);
      tick();
      drive(1, 64'h208, 64'h0, 5'd6, 6'b000100, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("pre_async_valid", {63'd0, mem_valid}, 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      $display("tx async reset with count=2");
      chk("async_valid", {63'd0, mem_valid}, 64'd0);
      chk("async_ready", {63'd0, ex_ready}, 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      mem_ready = 1'b1;
      drive(1, 64'h20, 64'h0, 5'd7, 6'b000100, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      $display("tx post-reset add addr=0x20 rd=7");
      chk("post_rst_valid", {63'd0, mem_valid}, 64'd1);
      chk("post_rst_addr", mem_addr, 64'h20);
      chk("post_rst_rd", {59'd0, mem_rd}, 64'd7);
      tick();

      // random traffic
      for (int i = 0; i < 10000; i++) begin
         drive(($urandom % 4) != 0, {$urandom, $urandom}, {$urandom, $urandom},
               5'($urandom), 6'($urandom), ($urandom % 2) == 1, {$urandom, $urandom});
         mem_ready = ($urandom % 3) != 0;
         flush     = ($urandom % 64) == 0;
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      flush = 1'b0;
      mem_ready = 1'b1;
      tick(); tick(); tick();
      chk("final_empty", {63'd0, mem_valid}, 64'd0);
      $display("random traffic: pushed=%0d drained=%0d illegal_ctl_enqueued=%0d",
               pushes, pops, illegal_seen);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
